ps2_direction_decoder: RTL and testbench

Receives PS/2 keyboard frames on a single 50 MHz clock domain and decodes them into per-player bike orientation words for the lightbike processor. It sits directly upstream of the processor's decode-stage register file and drives the orientation registers that game software reads. It also provides a start-key level. The block contains a bit-level receiver FSM, a parity and framing checker, a timeout watchdog, and a make/break/extended scan-code tracker with illegal-reversal rejection.

---
 rtl/ps2_direction_decoder_if.sv | 37 +++
 rtl/ps2_direction_decoder.sv | 201 ++++++++++++++++++++
 tb/tb_ps2_direction_decoder.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_direction_decoder_if.sv
// PS/2 pin inputs and decoded outputs of the direction decoder.
// Latency: none (wiring only).
// Backpressure: none; the outputs are pulses and levels that the consumer samples.
interface ps2_direction_decoder_if;
   logic        ps2_clk;
   logic        ps2_data;
   logic [7:0]  scan_code;
   logic        scan_valid;
   logic        frame_error;
   logic [31:0] dir_blue;
   logic [31:0] dir_red;
   logic        start_key;

   // Decoder side: takes the raw pins and drives the decoded results.
   modport slave (
      input  ps2_clk,
      input  ps2_data,
      output scan_code,
      output scan_valid,
      output frame_error,
      output dir_blue,
      output dir_red,
      output start_key
   );

   // Keyboard/consumer side.
   modport master (
      output ps2_clk,
      output ps2_data,
      input  scan_code,
      input  scan_valid,
      input  frame_error,
      input  dir_blue,
      input  dir_red,
      input  start_key
   );
endinterface

// File: rtl/ps2_direction_decoder.sv
// PS/2 receiver and scan-code decoder producing per-player bike orientations and a start-key level.
// Latency: scan_valid/frame_error 1 clock after the detected stop edge; dir_*/start_key 1 clock after scan_valid.
// Backpressure: none; every frame is consumed as it arrives, and frame_error resynchronises the prefix tracker.
module ps2_direction_decoder #(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input logic                  clock,
   input logic                  reset,
   ps2_direction_decoder_if.slave bus
);

   localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } rxState_t;

   // Synchroniser, edge detection and receiver state.
   logic [1:0]      clkSync;
   logic [1:0]      dataSync;
   logic            clkPrev;
   logic            fallEdge;
   logic            edgeData;

   rxState_t        rxState;
   logic [2:0]      bitCnt;
   logic [7:0]      shiftReg;
   logic            parityBit;
   logic [WD_W-1:0] wdCnt;

   logic [7:0]      scanCodeReg;
   logic            scanValidReg;
   logic            frameErrorReg;

   // Decoder state.
   logic            ext;
   logic            brk;
   logic [1:0]      blueDir;
   logic [1:0]      redDir;
   logic            startKey;

   // Key lookups for the byte currently presented with scanValidReg.
   logic            blueReqVld;
   logic [1:0]      blueReq;
   logic            redReqVld;
   logic [1:0]      redReq;
   logic            frameGood;

   // Two-flop synchronisers; idle-high reset so leaving reset never fakes a falling edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         clkSync  <= 2'b11;
         dataSync <= 2'b11;
      end else begin
         clkSync  <= {clkSync[0], bus.ps2_clk};
         dataSync <= {dataSync[0], bus.ps2_data};
      end
   end

   // Registered falling-edge detect, with the data bit captured alongside it.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         clkPrev  <= 1'b1;
         fallEdge <= 1'b0;
         edgeData <= 1'b1;
      end else begin
         clkPrev  <= clkSync[1];
         fallEdge <= clkPrev & ~clkSync[1];
         edgeData <= dataSync[1];
      end
   end

   // Odd parity over the eight data bits plus the parity bit, and the stop bit must be high.
   assign frameGood = (^{shiftReg, parityBit}) & edgeData;

   // Receiver FSM with watchdog; pulses and scan_code are registered here.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rxState       <= IDLE;
         bitCnt        <= 3'd0;
         shiftReg      <= 8'h00;
         parityBit     <= 1'b0;
         wdCnt         <= '0;
         scanCodeReg   <= 8'h00;
         scanValidReg  <= 1'b0;
         frameErrorReg <= 1'b0;
      end else begin
         scanValidReg  <= 1'b0;
         frameErrorReg <= 1'b0;

         if (fallEdge) begin
            // An edge always restarts the watchdog, so a timeout can never meet a stop edge.
            wdCnt <= '0;
            unique case (rxState)
               IDLE: begin
                  // A high bit while idle is line noise; ignore it silently.
                  if (!edgeData) begin
                     rxState <= SHIFT;
                     bitCnt  <= 3'd0;
                  end
               end
               SHIFT: begin
                  shiftReg <= {edgeData, shiftReg[7:1]};
                  bitCnt   <= bitCnt + 3'd1;
                  if (bitCnt == 3'd7) begin
                     rxState <= PARITY;
                  end
               end
               PARITY: begin
                  parityBit <= edgeData;
                  rxState   <= STOP;
               end
               STOP: begin
                  if (frameGood) begin
                     scanCodeReg  <= shiftReg;
                     scanValidReg <= 1'b1;
                  end else begin
                     frameErrorReg <= 1'b1;
                  end
                  rxState <= IDLE;
               end
               default: rxState <= IDLE;
            endcase
         end else if (rxState == IDLE) begin
            wdCnt <= '0;
         end else if (wdCnt == WD_LAST) begin
            // Keyboard stalled mid-frame: abandon it.
            frameErrorReg <= 1'b1;
            rxState       <= IDLE;
            bitCnt        <= 3'd0;
            wdCnt         <= '0;
         end else begin
            wdCnt <= wdCnt + WD_W'(1);
         end
      end
   end

   // Map the received byte to a direction request for each player.
   always_comb begin
      blueReqVld = 1'b0;
      blueReq    = 2'd0;
      redReqVld  = 1'b0;
      redReq     = 2'd0;
      unique case (scanCodeReg)
         8'h75: begin blueReqVld = 1'b1; blueReq = 2'd0; end
         8'h74: begin blueReqVld = 1'b1; blueReq = 2'd1; end
         8'h72: begin blueReqVld = 1'b1; blueReq = 2'd2; end
         8'h6B: begin blueReqVld = 1'b1; blueReq = 2'd3; end
         8'h1D: begin redReqVld  = 1'b1; redReq  = 2'd0; end
         8'h23: begin redReqVld  = 1'b1; redReq  = 2'd1; end
         8'h1B: begin redReqVld  = 1'b1; redReq  = 2'd2; end
         8'h1C: begin redReqVld  = 1'b1; redReq  = 2'd3; end
         default: begin end
      endcase
   end

   // Prefix tracking and key events; a direction that would reverse the bike (current XOR 2) is dropped.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ext      <= 1'b0;
         brk      <= 1'b0;
         blueDir  <= 2'd1;
         redDir   <= 2'd3;
         startKey <= 1'b0;
      end else if (frameErrorReg) begin
         ext <= 1'b0;
         brk <= 1'b0;
      end else if (scanValidReg) begin
         if (scanCodeReg == 8'hE0) begin
            ext <= 1'b1;
         end else if (scanCodeReg == 8'hF0) begin
            brk <= 1'b1;
         end else begin
            ext <= 1'b0;
            brk <= 1'b0;
            if (!ext && scanCodeReg == 8'h29) begin
               startKey <= !brk;
            end else if (!brk) begin
               if (ext && blueReqVld && blueReq != (blueDir ^ 2'd2)) begin
                  blueDir <= blueReq;
               end
               if (!ext && redReqVld && redReq != (redDir ^ 2'd2)) begin
                  redDir <= redReq;
               end
            end
         end
      end
   end

   assign bus.scan_code   = scanCodeReg;
   assign bus.scan_valid  = scanValidReg;
   assign bus.frame_error = frameErrorReg;
   assign bus.dir_blue    = {30'd0, blueDir};
   assign bus.dir_red     = {30'd0, redDir};
   assign bus.start_key   = startKey;

endmodule

// File: tb/tb_ps2_direction_decoder.sv
// Scoreboard bench for ps2_direction_decoder: frames push expected results, a monitor pops on each pulse.
// Latency: checks the pulse cycle, then dir/start one cycle later.
// Backpressure: none; the monitor must keep up with every pulse.
module tb_ps2_direction_decoder;

   localparam int TIMEOUT = 200;
   localparam int HALF    = 20;

   typedef struct {
      bit         isErr;
      logic [7:0] code;
      logic [1:0] blue;
      logic [1:0] red;
      logic       start;
   } exp_t;

   logic clock;
   logic reset;
   int   checks;
   int   errors;
   exp_t expQ[$];

   ps2_direction_decoder_if bus ();

   ps2_direction_decoder #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   initial clock = 1'b0;
   always #10 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic waitClk(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic sendBit(input logic b);
      bus.ps2_data = b;
      waitClk(HALF);
      bus.ps2_clk = 1'b0;
      waitClk(HALF);
      bus.ps2_clk = 1'b1;
   endtask

   // Full frame; expected post-state is pushed before the bits go out.
   task automatic frame(input logic [7:0] code, input bit goodPar, input bit isErr,
                        input logic [7:0] expCode, input logic [1:0] blue,
                        input logic [1:0] red, input logic start);
      exp_t e;
      e.isErr = isErr; e.code = expCode; e.blue = blue; e.red = red; e.start = start;
      expQ.push_back(e);
      sendBit(1'b0);
      for (int i = 0; i < 8; i++) sendBit(code[i]);
      sendBit(goodPar ? ~(^code) : (^code));
      sendBit(1'b1);
   endtask

   task automatic partial(input logic [7:0] code, input int nBits);
      sendBit(1'b0);
      for (int i = 0; i < nBits; i++) sendBit(code[i]);
   endtask

   // Monitor: pop one expectation per pulse, then check the decoded state a cycle later.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (!reset && (bus.scan_valid || bus.frame_error)) begin
            chk("pulse_exclusive", 32'(bus.scan_valid & bus.frame_error), 32'd0);
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pulse actual valid=%0b err=%0b required none at %0t",
                        bus.scan_valid, bus.frame_error, $time);
            end else begin
               e = expQ.pop_front();
               chk("pulse_kind_err", 32'(bus.frame_error), 32'(e.isErr));
               chk("scan_code", 32'(bus.scan_code), 32'(e.code));
               @(negedge clock);
               chk("pulse_width", 32'(bus.scan_valid | bus.frame_error), 32'd0);
               chk("dir_blue", bus.dir_blue, {30'd0, e.blue});
               chk("dir_red", bus.dir_red, {30'd0, e.red});
               chk("start_key", 32'(bus.start_key), 32'(e.start));
            end
         end
      end
   end

   initial begin
      int n;
      checks = 0;
      errors = 0;
      reset = 1'b1;
      bus.ps2_clk = 1'b1;
      bus.ps2_data = 1'b1;
      waitClk(5);
      reset = 1'b0;

      // Quiet line: nothing should happen.
      waitClk(2 * TIMEOUT);
      chk("idle_blue", bus.dir_blue, 32'd1);
      chk("idle_red", bus.dir_red, 32'd3);
      chk("idle_start", 32'(bus.start_key), 32'd0);
      chk("idle_code", 32'(bus.scan_code), 32'd0);

      //    code   par  err  expCode blue red start
      frame(8'h1D, 1, 0, 8'h1D, 2'd1, 2'd0, 1'b0);  // W: red up
      frame(8'h1B, 1, 0, 8'h1B, 2'd1, 2'd0, 1'b0);  // S: reversal rejected
      frame(8'hE0, 1, 0, 8'hE0, 2'd1, 2'd0, 1'b0);
      frame(8'h72, 1, 0, 8'h72, 2'd2, 2'd0, 1'b0);  // ext down: blue down
      frame(8'hE0, 1, 0, 8'hE0, 2'd2, 2'd0, 1'b0);
      frame(8'hF0, 1, 0, 8'hF0, 2'd2, 2'd0, 1'b0);
      frame(8'h72, 1, 0, 8'h72, 2'd2, 2'd0, 1'b0);  // break: no change
      frame(8'h75, 1, 0, 8'h75, 2'd2, 2'd0, 1'b0);  // no prefix: unmapped
      frame(8'hE0, 1, 0, 8'hE0, 2'd2, 2'd0, 1'b0);
      frame(8'h75, 1, 0, 8'h75, 2'd2, 2'd0, 1'b0);  // ext up: reversal of down
      frame(8'h29, 0, 1, 8'h75, 2'd2, 2'd0, 1'b0);  // bad parity
      frame(8'h29, 1, 0, 8'h29, 2'd2, 2'd0, 1'b1);  // space make
      frame(8'hF0, 1, 0, 8'hF0, 2'd2, 2'd0, 1'b1);
      frame(8'h29, 1, 0, 8'h29, 2'd2, 2'd0, 1'b0);  // space break
      frame(8'hE0, 1, 0, 8'hE0, 2'd2, 2'd0, 1'b0);
      frame(8'h1D, 0, 1, 8'hE0, 2'd2, 2'd0, 1'b0);  // error clears ext
      frame(8'h6B, 1, 0, 8'h6B, 2'd2, 2'd0, 1'b0);  // so 6B is unmapped

      // Stalled frame: watchdog error, then normal reception resumes.
      begin
         exp_t e;
         e.isErr = 1'b1; e.code = 8'h6B; e.blue = 2'd2; e.red = 2'd0; e.start = 1'b0;
         expQ.push_back(e);
      end
      partial(8'h23, 4);
      waitClk(2 * TIMEOUT);
      frame(8'h23, 1, 0, 8'h23, 2'd2, 2'd1, 1'b0);  // D: red right
      frame(8'h23, 1, 0, 8'h23, 2'd2, 2'd1, 1'b0);  // typematic repeat

      // Reset in the middle of a frame.
      n = 0;
      while (expQ.size() != 0 && n < 2000) begin
         waitClk(1);
         n++;
      end
      waitClk(3);
      partial(8'h1C, 5);
      waitClk(3);
      reset = 1'b1;
      #1;
      chk("rst_blue", bus.dir_blue, 32'd1);
      chk("rst_red", bus.dir_red, 32'd3);
      chk("rst_start", 32'(bus.start_key), 32'd0);
      chk("rst_code", 32'(bus.scan_code), 32'd0);
      chk("rst_valid", 32'(bus.scan_valid), 32'd0);
      chk("rst_err", 32'(bus.frame_error), 32'd0);
      bus.ps2_clk = 1'b1;
      bus.ps2_data = 1'b1;
      waitClk(5);
      reset = 1'b0;
      waitClk(5);
      frame(8'h1D, 1, 0, 8'h1D, 2'd1, 2'd0, 1'b0);  // decodes normally after reset

      n = 0;
      while (expQ.size() != 0 && n < 2000) begin
         waitClk(1);
         n++;
      end
      chk("queue_drained", 32'(expQ.size()), 32'd0);
      waitClk(5);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
